latch_bank_wr_ctrl: RTL and testbench



---
 rtl/latch_bank_wr_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_latch_bank_wr_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer and round-robin arbiter for a latch-based register bank.
// NREQ requesters share one write path. Each write takes three states:
// SETUP drives the data, OPEN pulses one word gate low, and HOLD keeps the
// data stable while that gate closes. A bank-wide clear takes one CLEAR state.
// Every output comes straight from a flop, so the latch gates and the clear
// cannot glitch.
module latch_bank_wr_ctrl #(
   parameter int NREQ = 4,
   parameter int AW   = 3,
   parameter int DW   = 8
) (
   input  logic                 CP,
   input  logic                 CD,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ*AW-1:0]   ADDR,
   input  logic [NREQ*DW-1:0]   WDATA,
   output logic [NREQ-1:0]      GNT,
   output logic [NREQ-1:0]      ACK,
   input  logic                 CLR_REQ,
   output logic                 CLR_ACK,
   output logic [DW-1:0]        LD_D,
   output logic [(2**AW)-1:0]   LD_GN,
   output logic                 LD_CD,
   output logic                 BUSY
);

   localparam int NW = 2**AW;
   localparam int RW = $clog2(NREQ);

   localparam logic [NREQ-1:0] ONE_REQ  = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [NW-1:0]   ONE_WORD = {{(NW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_OPEN  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_CLEAR = 3'd4
   } state_t;

   state_t             state_r;
   state_t             next_state_s;

   logic [RW-1:0]      rr_r;
   logic [RW-1:0]      w_r;
   logic [AW-1:0]      waddr_r;
   logic [DW-1:0]      ld_d_r;
   logic [NW-1:0]      ld_gn_r;
   logic               ld_cd_r;
   logic [NREQ-1:0]    gnt_r;
   logic [NREQ-1:0]    ack_r;
   logic               clr_ack_r;
   logic               busy_r;

   logic [RW-1:0]      win_s;
   logic               any_req_s;
   logic               load_s;
   logic [AW-1:0]      sel_addr_s;
   logic [DW-1:0]      sel_data_s;
   logic [NREQ-1:0]    gnt_nx_s;
   logic [NREQ-1:0]    ack_nx_s;
   logic [NW-1:0]      ld_gn_nx_s;
   logic               ld_cd_nx_s;
   logic               clr_ack_nx_s;
   logic               busy_nx_s;

   // Pick the first set request bit, searching upward from ptr+1 (mod NREQ).
   // The loop runs from the farthest candidate to the nearest, so the nearest
   // set bit is the one kept.
   function automatic logic [RW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [RW-1:0]   ptr);
      logic [RW-1:0] pick;
      int            idx;
      pick = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         idx  = (int'(ptr) + k) % NREQ;
         pick = req[RW'(idx)] ? RW'(idx) : pick;
      end
      return pick;
   endfunction

   assign win_s     = rr_pick(REQ, rr_r);
   assign any_req_s = |REQ;
   assign load_s    = (next_state_s == ST_SETUP);

   // Select the winner's address and data with an AND-OR mux.
   always_comb begin
      sel_addr_s = {AW{1'b0}};
      sel_data_s = {DW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         sel_addr_s = sel_addr_s | (ADDR[i*AW +: AW]  & {AW{win_s == RW'(i)}});
         sel_data_s = sel_data_s | (WDATA[i*DW +: DW] & {DW{win_s == RW'(i)}});
      end
   end

   // State register.
   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state. IDLE and HOLD are the decision points, and a clear wins over writes.
   always_comb begin
      next_state_s = ST_IDLE;
      case (state_r)
         ST_IDLE, ST_HOLD: begin
            if (CLR_REQ) begin
               next_state_s = ST_CLEAR;
            end else if (any_req_s) begin
               next_state_s = ST_SETUP;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_SETUP: next_state_s = ST_OPEN;
         ST_OPEN:  next_state_s = ST_HOLD;
         ST_CLEAR: next_state_s = ST_IDLE;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // Output decode. This logic computes the value each output flop takes in the coming state.
   always_comb begin
      gnt_nx_s     = {NREQ{1'b0}};
      ack_nx_s     = {NREQ{1'b0}};
      ld_gn_nx_s   = {NW{1'b1}};
      ld_cd_nx_s   = (next_state_s != ST_CLEAR);
      clr_ack_nx_s = (state_r == ST_CLEAR);
      busy_nx_s    = (next_state_s != ST_IDLE);
      if (load_s) begin
         gnt_nx_s = ONE_REQ << win_s;
      end else begin
         gnt_nx_s = {NREQ{1'b0}};
      end
      if (next_state_s == ST_HOLD) begin
         ack_nx_s = ONE_REQ << w_r;
      end else begin
         ack_nx_s = {NREQ{1'b0}};
      end
      if (next_state_s == ST_OPEN) begin
         ld_gn_nx_s = ~(ONE_WORD << waddr_r);
      end else begin
         ld_gn_nx_s = {NW{1'b1}};
      end
   end

   // Output and datapath registers. Reset closes every gate and clears the bank.
   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         rr_r      <= RW'(NREQ - 1);
         w_r       <= {RW{1'b0}};
         waddr_r   <= {AW{1'b0}};
         ld_d_r    <= {DW{1'b0}};
         ld_gn_r   <= {NW{1'b1}};
         ld_cd_r   <= 1'b0;
         gnt_r     <= {NREQ{1'b0}};
         ack_r     <= {NREQ{1'b0}};
         clr_ack_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         if (load_s) begin
            rr_r    <= win_s;
            w_r     <= win_s;
            waddr_r <= sel_addr_s;
            ld_d_r  <= sel_data_s;
         end
         ld_gn_r   <= ld_gn_nx_s;
         ld_cd_r   <= ld_cd_nx_s;
         gnt_r     <= gnt_nx_s;
         ack_r     <= ack_nx_s;
         clr_ack_r <= clr_ack_nx_s;
         busy_r    <= busy_nx_s;
      end
   end

   assign GNT     = gnt_r;
   assign ACK     = ack_r;
   assign CLR_ACK = clr_ack_r;
   assign LD_D    = ld_d_r;
   assign LD_GN   = ld_gn_r;
   assign LD_CD   = ld_cd_r;
   assign BUSY    = busy_r;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Directed testbench for latch_bank_wr_ctrl. Inputs are driven on the falling
// clock edge and outputs are checked there as well. A background monitor
// checks the gate, clear and data-stability invariants on every cycle.
module tb_latch_bank_wr_ctrl;

   localparam int NREQ = 4;
   localparam int AW   = 3;
   localparam int DW   = 8;

   logic                 CP;
   logic                 CD;
   logic [NREQ-1:0]      REQ;
   logic [NREQ*AW-1:0]   ADDR;
   logic [NREQ*DW-1:0]   WDATA;
   logic [NREQ-1:0]      GNT;
   logic [NREQ-1:0]      ACK;
   logic                 CLR_REQ;
   logic                 CLR_ACK;
   logic [DW-1:0]        LD_D;
   logic [(2**AW)-1:0]   LD_GN;
   logic                 LD_CD;
   logic                 BUSY;

   int checks = 0;
   int errors = 0;

   logic [3:0] e_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] e_gn  [5] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFD};
   logic [7:0] e_d   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

   logic [7:0] prev_d   = 8'h00;
   logic       prev_low = 1'b0;
   logic       prev_cd  = 1'b0;

   latch_bank_wr_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .CP(CP), .CD(CD), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA),
      .GNT(GNT), .ACK(ACK), .CLR_REQ(CLR_REQ), .CLR_ACK(CLR_ACK),
      .LD_D(LD_D), .LD_GN(LD_GN), .LD_CD(LD_CD), .BUSY(BUSY)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CP);
      @(negedge CP);
   endtask

   task automatic do_reset();
      CD = 1'b0;
      #1;
      check("rst_gn",    32'(LD_GN),   32'hFF);
      check("rst_cd",    32'(LD_CD),   32'h0);
      check("rst_d",     32'(LD_D),    32'h0);
      check("rst_gnt",   32'(GNT),     32'h0);
      check("rst_ack",   32'(ACK),     32'h0);
      check("rst_busy",  32'(BUSY),    32'h0);
      check("rst_clrak", 32'(CLR_ACK), 32'h0);
      tick();
      check("rst_cd_held", 32'(LD_CD), 32'h0);
      CD = 1'b1;
      tick();
      check("rst_cd_rel", 32'(LD_CD), 32'h1);
      check("rst_idle",   32'(BUSY),  32'h0);
   endtask

   // Invariant monitor: at most one gate open, no gate open while clearing,
   // and data frozen while a gate is open and for the cycle after it closes.
   always @(negedge CP) begin
      #1;
      if (CD && prev_cd) begin
         check("one_gate",      32'($countones(~LD_GN) <= 1), 32'h1);
         check("gate_vs_clear", 32'((LD_GN != 8'hFF) && !LD_CD), 32'h0);
         if ((LD_GN != 8'hFF) || prev_low) begin
            check("ld_d_stable", 32'(LD_D), 32'(prev_d));
         end
      end
      prev_d   = LD_D;
      prev_low = (LD_GN != 8'hFF);
      prev_cd  = CD;
   end

   initial begin
      CD = 1'b0; REQ = 4'b0000; ADDR = '0; WDATA = '0; CLR_REQ = 1'b0;
      @(negedge CP);
      do_reset();

      // Single write: requester 0 writes word 5.
      REQ = 4'b0001; ADDR = {3'd0, 3'd0, 3'd0, 3'd5}; WDATA = {8'h00, 8'h00, 8'h00, 8'hA5};
      tick();
      check("t1_gnt",  32'(GNT),   32'h1);
      check("t1_busy", 32'(BUSY),  32'h1);
      check("t1_d",    32'(LD_D),  32'hA5);
      check("t1_gn_s", 32'(LD_GN), 32'hFF);
      REQ = 4'b0000;
      tick();
      check("t1_gn_o", 32'(LD_GN), 32'hDF);
      check("t1_d_o",  32'(LD_D),  32'hA5);
      check("t1_gnt0", 32'(GNT),   32'h0);
      check("t1_bsy2", 32'(BUSY),  32'h1);
      tick();
      check("t1_ack",  32'(ACK),   32'h1);
      check("t1_gn_h", 32'(LD_GN), 32'hFF);
      check("t1_bsy3", 32'(BUSY),  32'h1);
      tick();
      check("t1_idle", 32'(BUSY),  32'h0);
      check("t1_ack0", 32'(ACK),   32'h0);

      // Round robin: all four requesters keep requesting.
      do_reset();
      ADDR = {3'd4, 3'd3, 3'd2, 3'd1}; WDATA = {8'h44, 8'h33, 8'h22, 8'h11};
      REQ = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("rr_gnt", 32'(GNT),  32'(e_gnt[n]));
         check("rr_d",   32'(LD_D), 32'(e_d[n]));
         if (n == 4) REQ = 4'b0000;
         tick();
         check("rr_gn",  32'(LD_GN), 32'(e_gn[n]));
         tick();
         check("rr_ack", 32'(ACK),  32'(e_gnt[n]));
      end
      tick();
      check("rr_idle", 32'(BUSY), 32'h0);

      // Clear and write requested together: the clear goes first.
      CLR_REQ = 1'b1; REQ = 4'b0010;
      ADDR = {3'd0, 3'd0, 3'd6, 3'd0}; WDATA = {8'h00, 8'h00, 8'h5A, 8'h00};
      tick();
      check("clr_cd",   32'(LD_CD), 32'h0);
      check("clr_gn",   32'(LD_GN), 32'hFF);
      check("clr_gnt",  32'(GNT),   32'h0);
      check("clr_busy", 32'(BUSY),  32'h1);
      CLR_REQ = 1'b0;
      tick();
      check("clr_ack",  32'(CLR_ACK), 32'h1);
      check("clr_cd1",  32'(LD_CD),   32'h1);
      check("clr_idle", 32'(BUSY),    32'h0);
      tick();
      check("clr_gnt1", 32'(GNT),     32'h2);
      check("clr_d",    32'(LD_D),    32'h5A);
      check("clr_ack0", 32'(CLR_ACK), 32'h0);
      REQ = 4'b0000;
      tick();
      check("clr_gn_o", 32'(LD_GN), 32'hBF);
      tick();
      check("clr_wack", 32'(ACK),   32'h2);
      tick();

      // Reset during OPEN of requester 0's write to word 3.
      REQ = 4'b0001; ADDR = {3'd0, 3'd0, 3'd0, 3'd3}; WDATA = {8'h00, 8'h00, 8'h00, 8'h77};
      tick();
      check("mr_gnt", 32'(GNT), 32'h1);
      REQ = 4'b0000;
      tick();
      check("mr_gn_o", 32'(LD_GN), 32'hF7);
      CD = 1'b0;
      #1;
      check("mr_gn",   32'(LD_GN), 32'hFF);
      check("mr_cd",   32'(LD_CD), 32'h0);
      check("mr_busy", 32'(BUSY),  32'h0);
      tick();
      check("mr_noack", 32'(ACK),   32'h0);
      check("mr_nognt", 32'(GNT),   32'h0);
      check("mr_cd2",   32'(LD_CD), 32'h0);
      REQ = 4'b0011; CD = 1'b1;
      tick();
      check("mr_cd_rel", 32'(LD_CD), 32'h1);
      check("mr_rr0",    32'(GNT),   32'h1);
      check("mr_d",      32'(LD_D),  32'h77);
      REQ = 4'b0000;
      tick();
      check("mr_gn_o2", 32'(LD_GN), 32'hF7);
      tick();
      check("mr_ack", 32'(ACK), 32'h1);
      tick();

      // Back-to-back writes to words 0 and 7; WDATA changes right after each grant.
      REQ = 4'b1100; ADDR = {3'd7, 3'd0, 3'd0, 3'd0}; WDATA = {8'hC3, 8'h3C, 8'h00, 8'h00};
      tick();
      check("bb_gnt2", 32'(GNT),  32'h4);
      check("bb_d0",   32'(LD_D), 32'h3C);
      WDATA[23:16] = 8'hFF; REQ = 4'b1000;
      tick();
      check("bb_gn0",  32'(LD_GN), 32'hFE);
      check("bb_d0o",  32'(LD_D),  32'h3C);
      tick();
      check("bb_ack2", 32'(ACK),   32'h4);
      check("bb_d0h",  32'(LD_D),  32'h3C);
      check("bb_gnh",  32'(LD_GN), 32'hFF);
      tick();
      check("bb_gnt3", 32'(GNT),  32'h8);
      check("bb_d7",   32'(LD_D), 32'hC3);
      WDATA[31:24] = 8'h00; REQ = 4'b0000;
      tick();
      check("bb_gn7",  32'(LD_GN), 32'h7F);
      check("bb_d7o",  32'(LD_D),  32'hC3);
      tick();
      check("bb_ack3", 32'(ACK),   32'h8);
      check("bb_d7h",  32'(LD_D),  32'hC3);
      tick();
      check("bb_idle", 32'(BUSY),  32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
